// File: rtl/sfq_merge_arb.sv
// ----------------------------------------------------------------------------
// sfq_merge_arb
//   Gated N-channel pulse merge with round-robin serialisation.
//   Each channel pulse AI[i] is qualified by BI[i]. Qualified pulses are never
//   lost while the channel counter has headroom: they are queued per channel
//   and granted one per clock, round-robin, onto a single output line through
//   a LAT-deep register pipeline.
//
//   Optional build macro: SFQ_MERGE_DROP_CNT_EN adds DCNT, a saturating 8-bit
//   count of all dropped pulses.
//
// Ports
//   TI    clock, rising edge
//   RI    synchronous active-high reset, priority over all inputs
//   AI    per-channel pulse inputs (one cycle high = one pulse)
//   BI    per-channel enables, sampled with AI
//   ABO   merged output pulse
//   ACH   channel index of the current ABO pulse, 0 when ABO=0
//   BUSY  registered: any pending counter nonzero
//   OVF   sticky per-channel overflow (pulse dropped), cleared only by RI
//   DCNT  (optional) total dropped pulses, saturates at 255
// ----------------------------------------------------------------------------
module sfq_merge_arb #(
    parameter  int N_CH  = 4,
    parameter  int CNT_W = 3,
    parameter  int LAT   = 1,
    localparam int IW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            TI,
    input  logic            RI,
    input  logic [N_CH-1:0] AI,
    input  logic [N_CH-1:0] BI,
    output logic            ABO,
    output logic [IW-1:0]   ACH,
    output logic            BUSY,
    output logic [N_CH-1:0] OVF
`ifdef SFQ_MERGE_DROP_CNT_EN
    ,
    output logic [7:0]      DCNT
`endif
);

    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];
    logic [N_CH-1:0]  q;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  gnt_oh;
    logic [N_CH-1:0]  drop;
    logic             gnt_vld;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_nxt;
    logic             busy_nxt;
    int               arb_idx;

    logic [LAT-1:0]   vld_pipe;
    logic [IW-1:0]    idx_pipe [LAT];

    // A fresh qualified pulse requests in its own cycle (bypass), so an
    // idle channel does not pay an extra clock of counter latency.
    always_comb begin
        q = AI & BI;
        for (int i = 0; i < N_CH; i++) begin
            req[i] = (cnt[i] != '0) | q[i];
        end
    end

    // Round-robin: first requester at or after ptr, with wrap.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        arb_idx = 0;
        for (int k = 0; k < N_CH; k++) begin
            arb_idx = int'(ptr) + k;
            if (arb_idx >= N_CH) begin
                arb_idx = arb_idx - N_CH;
            end
            if (!gnt_vld && req[arb_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(arb_idx);
            end
        end
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
        if (!gnt_vld) begin
            ptr_nxt = ptr;
        end else if (gnt_idx == IW'(N_CH - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = gnt_idx + IW'(1);
        end
    end

    // A grant on a channel that also received a pulse this cycle consumes
    // exactly that pulse, so the counter is left unchanged.
    always_comb begin
        busy_nxt = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            drop[i]    = 1'b0;
            case ({q[i], gnt_oh[i]})
                2'b10: begin
                    if (cnt[i] == CMAX) begin
                        drop[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                2'b01:   cnt_nxt[i] = cnt[i] - CNT_W'(1);
                default: cnt_nxt[i] = cnt[i];
            endcase
            busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
        end
    end

    always_ff @(posedge TI) begin
        if (RI) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
            ptr  <= '0;
            BUSY <= 1'b0;
            OVF  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            ptr  <= ptr_nxt;
            BUSY <= busy_nxt;
            OVF  <= OVF | drop;
        end
    end

    // gnt_idx is 0 whenever gnt_vld is 0, so ACH idles at 0 for free.
    always_ff @(posedge TI) begin
        if (RI) begin
            vld_pipe <= '0;
            for (int s = 0; s < LAT; s++) begin
                idx_pipe[s] <= '0;
            end
        end else begin
            vld_pipe[0] <= gnt_vld;
            idx_pipe[0] <= gnt_idx;
            for (int s = 1; s < LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    assign ABO = vld_pipe[LAT-1];
    assign ACH = idx_pipe[LAT-1];

`ifdef SFQ_MERGE_DROP_CNT_EN
    logic [4:0] ndrop;
    logic [8:0] dsum;

    // Several channels may drop on the same edge.
    always_comb begin
        ndrop = '0;
        for (int i = 0; i < N_CH; i++) begin
            ndrop = ndrop + 5'(drop[i]);
        end
        dsum = {1'b0, DCNT} + 9'(ndrop);
    end

    always_ff @(posedge TI) begin
        if (RI) begin
            DCNT <= '0;
        end else if (dsum > 9'd255) begin
            DCNT <= 8'hFF;
        end else begin
            DCNT <= dsum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_sfq_merge_arb.sv
module tb_sfq_merge_arb;

    typedef struct {
        int cyc;
        int ch;
    } exp_t;

    logic       clk = 1'b0;
    logic       RI;
    logic [3:0] AI1, BI1, AI3, BI3;
    logic       ABO1, ABO3, BUSY1, BUSY3;
    logic [1:0] ACH1, ACH3;
    logic [3:0] OVF1, OVF3;
`ifdef SFQ_MERGE_DROP_CNT_EN
    logic [7:0] DCNT1, DCNT3;
`endif

    int   ncyc   = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    sfq_merge_arb #(.N_CH(4), .CNT_W(3), .LAT(1)) dut1 (
        .TI(clk), .RI(RI), .AI(AI1), .BI(BI1),
        .ABO(ABO1), .ACH(ACH1), .BUSY(BUSY1), .OVF(OVF1)
`ifdef SFQ_MERGE_DROP_CNT_EN
        , .DCNT(DCNT1)
`endif
    );

    sfq_merge_arb #(.N_CH(4), .CNT_W(3), .LAT(3)) dut3 (
        .TI(clk), .RI(RI), .AI(AI3), .BI(BI3),
        .ABO(ABO3), .ACH(ACH3), .BUSY(BUSY3), .OVF(OVF3)
`ifdef SFQ_MERGE_DROP_CNT_EN
        , .DCNT(DCNT3)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Expected pulse for a grant at edge e: visible at the negedge after edge e+LAT-1.
    task automatic push1(input int e, input int ch);
        exp_t x;
        x.cyc = e;
        x.ch  = ch;
        q1.push_back(x);
    endtask

    task automatic push3(input int e, input int ch);
        exp_t x;
        x.cyc = e + 2;
        x.ch  = ch;
        q3.push_back(x);
    endtask

    // Called at a negedge: drive dut1 inputs, return at the next negedge.
    task automatic tick(input logic [3:0] a, input logic [3:0] b);
        AI1 = a;
        BI1 = b;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ABO1 === 1'b1) begin
                if (q1.size() == 0) begin
                    chk("lat1_unexpected_abo_ach", int'(ACH1), -1);
                end else begin
                    exp_t x;
                    x = q1.pop_front();
                    chk("lat1_abo_cycle", ncyc, x.cyc);
                    chk("lat1_ach", int'(ACH1), x.ch);
                end
            end else begin
                chk("lat1_ach_idle", int'(ACH1), 0);
            end
            if (ABO3 === 1'b1) begin
                if (q3.size() == 0) begin
                    chk("lat3_unexpected_abo_ach", int'(ACH3), -1);
                end else begin
                    exp_t x;
                    x = q3.pop_front();
                    chk("lat3_abo_cycle", ncyc, x.cyc);
                    chk("lat3_ach", int'(ACH3), x.ch);
                end
            end else begin
                chk("lat3_ach_idle", int'(ACH3), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int e;
        RI  = 1'b1;
        AI1 = '0; BI1 = '0; AI3 = '0; BI3 = '0;
        @(negedge clk);
        tick(4'h0, 4'h0);
        tick(4'h0, 4'h0);
        chk("rst_abo",  int'(ABO1),  0);
        chk("rst_ach",  int'(ACH1),  0);
        chk("rst_busy", int'(BUSY1), 0);
        chk("rst_ovf",  int'(OVF1),  0);
        chk("rst_abo3", int'(ABO3),  0);
`ifdef SFQ_MERGE_DROP_CNT_EN
        chk("rst_dcnt", int'(DCNT1), 0);
`endif
        RI     = 1'b0;
        mon_en = 1'b1;

        // single bypass pulse on ch0
        push1(ncyc + 1, 0);
        tick(4'b0001, 4'b1111);
        chk("single_busy", int'(BUSY1), 0);
        tick(4'h0, 4'h0);
        tick(4'h0, 4'h0);
        chk("single_ovf", int'(OVF1), 0);

        // gated: ch1 enable low
        tick(4'b0010, 4'b1101);
        chk("gated_busy", int'(BUSY1), 0);
        tick(4'h0, 4'h0);
        tick(4'h0, 4'h0);

        // ptr is 1; a ch3 pulse brings it back to 0
        push1(ncyc + 1, 3);
        tick(4'b1000, 4'b1111);
        tick(4'h0, 4'h0);

        // burst on all four channels
        e = ncyc + 1;
        for (int i = 0; i < 4; i++) push1(e + i, i);
        tick(4'b1111, 4'b1111);
        chk("burst_busy0", int'(BUSY1), 1);
        tick(4'h0, 4'h0);
        chk("burst_busy1", int'(BUSY1), 1);
        tick(4'h0, 4'h0);
        chk("burst_busy2", int'(BUSY1), 1);
        tick(4'h0, 4'h0);
        chk("burst_busy3", int'(BUSY1), 0);
        chk("burst_ovf", int'(OVF1), 0);
        tick(4'h0, 4'h0);

        // sustained ch0+ch2: alternating grants, counters saturate and drop
        e = ncyc + 1;
        for (int j = 0; j < 34; j++) push1(e + j, (j % 2 == 0) ? 0 : 2);
        for (int j = 0; j < 20; j++) begin
            tick(4'b0101, 4'b1111);
            if (j == 13) chk("sat_ovf_before", int'(OVF1), 4'b0000);
            if (j == 14) chk("sat_ovf_ch2",    int'(OVF1), 4'b0100);
            if (j == 15) chk("sat_ovf_both",   int'(OVF1), 4'b0101);
`ifdef SFQ_MERGE_DROP_CNT_EN
            if (j == 14) chk("sat_dcnt_first", int'(DCNT1), 1);
`endif
        end
        chk("sat_busy", int'(BUSY1), 1);
`ifdef SFQ_MERGE_DROP_CNT_EN
        chk("sat_dcnt_total", int'(DCNT1), 6);
`endif
        for (int j = 0; j < 16; j++) tick(4'h0, 4'h0);
        chk("drain_busy", int'(BUSY1), 0);
        chk("drain_ovf_sticky", int'(OVF1), 4'b0101);

        // reset clears OVF
        RI = 1'b1;
        tick(4'h0, 4'h0);
        RI = 1'b0;
        chk("rst2_ovf",  int'(OVF1),  0);
        chk("rst2_busy", int'(BUSY1), 0);
`ifdef SFQ_MERGE_DROP_CNT_EN
        chk("rst2_dcnt", int'(DCNT1), 0);
`endif

        // reset during the second ABO cycle of a burst
        e = ncyc + 1;
        push1(e, 0);
        push1(e + 1, 1);
        tick(4'b1111, 4'b1111);
        tick(4'h0, 4'h0);
        RI = 1'b1;
        tick(4'h0, 4'h0);
        RI = 1'b0;
        chk("midrst_abo",  int'(ABO1),  0);
        chk("midrst_busy", int'(BUSY1), 0);
        chk("midrst_ach",  int'(ACH1),  0);
        for (int j = 0; j < 6; j++) tick(4'h0, 4'h0);

        // LAT=3 instance: single pulse, then RR pick from ptr=3
        push3(ncyc + 1, 2);
        AI3 = 4'b0100; BI3 = 4'b1111;
        tick(4'h0, 4'h0);
        AI3 = '0;
        for (int j = 0; j < 4; j++) tick(4'h0, 4'h0);
        e = ncyc + 1;
        push3(e, 3);
        push3(e + 1, 0);
        AI3 = 4'b1001;
        tick(4'h0, 4'h0);
        AI3 = '0;
        for (int j = 0; j < 6; j++) tick(4'h0, 4'h0);
        chk("lat3_busy", int'(BUSY3), 0);

        chk("lat1_queue_empty", q1.size(), 0);
        chk("lat3_queue_empty", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfq_merge_arb.md
Name: sfq_merge_arb

Overview:
- Parametrised successor to the two-input gated merge used in routing cells.
- Each of N_CH pulse channels is gated by a per-channel enable, as the clocked AND stage does.
- Qualified pulses are merged onto one output line, as the confluence buffer does. Unlike a plain confluence, simultaneous pulses are not lost: they are counted per channel and serialised round-robin, one per clock, through a LAT-stage DFF pipeline.
- Sits between channel splitters and a single shared downstream line.

Parameters:
- N_CH, 4, number of input channels (2..16).
- CNT_W, 3, width of each per-channel pending-pulse counter. Saturates at 2^CNT_W-1.
- LAT, 1, output pipeline depth in clocks (1..8).

Ports:
- TI  input  1  clock; all state updates on the rising edge.
- RI  input  1  reset, synchronous, active-high.
- AI  input  N_CH  per-channel pulse inputs; a bit high for one cycle = one pulse.
- BI  input  N_CH  per-channel enable, sampled in the same cycle as AI.
- ABO  output  1  merged output pulse.
- ACH  output  max(1,clog2(N_CH))  channel index of the current ABO pulse; 0 when ABO=0.
- BUSY  output  1  high while any pending counter is nonzero.
- OVF  output  N_CH  sticky per-channel overflow (pulse dropped).

Behaviour:
- Reset (RI=1 at an edge):
  - Clears all counters, the RR pointer, all pipeline stages and OVF.
  - Next cycle: ABO=0, ACH=0, BUSY=0, OVF=0.
  - RI has priority over all inputs.
  - Reset mid-operation discards pending and in-flight pulses; no pulse emerges afterwards.
- Qualification: q[i] = AI[i] & BI[i].
- Request: req[i] = (cnt[i] != 0) | q[i].
  - Bypass: a new pulse on an idle channel is eligible in its arrival cycle.
- Arbitration:
  - At most one grant per cycle.
  - Round-robin search starts at pointer ptr; lowest index at or after ptr (with wrap) with req=1 wins.
  - On a grant to channel g, ptr <= (g+1) mod N_CH. With no grant, ptr holds.
- Counter update per channel, each edge:
  - q=1, not granted: cnt+1 if cnt < max; otherwise the pulse is dropped and OVF[i] <= 1.
  - q=1, granted: cnt unchanged. Covers both bypass and a simultaneous arrival plus service.
  - q=0, granted: cnt-1.
  - q=0, not granted: hold.
- Pipeline:
  - The grant (valid, index) enters a LAT-deep register chain.
  - A pulse sampled at edge k with a grant at edge k drives ABO=1 and ACH=g during the cycle after edge k+LAT-1.
  - ABO is exactly one cycle wide per grant.
  - Back-to-back grants give ABO continuously high with ACH changing each cycle.
- BUSY is registered: the OR of the counters after the edge update.
- OVF bits clear only on reset.
- Throughput: 1 pulse/clock aggregate. Sustained aggregate input above 1/clock eventually saturates counters.

Optional Feature:
- Macro: SFQ_MERGE_DROP_CNT_EN.
- Defined:
  - Adds output port DCNT, 8 bits: total pulses dropped across all channels.
  - Saturates at 255.
  - Reset to 0 by RI.
  - Increments by the number of channels dropping in that cycle, which can exceed 1 per edge.
- Undefined: port and logic absent; drops are visible only through OVF.

Test Plan:
- N_CH=4, CNT_W=3, LAT=1, after reset. AI=0001, BI=1111 for one cycle -> ABO=1, ACH=0 for exactly the next cycle; BUSY stays 0; OVF=0000.
- AI=0010, BI=1101 for one cycle -> ABO never asserts, BUSY=0; gating verified.
- ptr=0. AI=1111, BI=1111 for one cycle -> ABO high for 4 consecutive cycles with ACH=0,1,2,3; BUSY high 3 cycles then 0; no OVF.
- AI=0101, BI=1111 held for 20 cycles -> ACH alternates 0,2,0,2…
  - cnt[0] and cnt[2] each grow by 1 every 2 cycles.
  - OVF[0] and OVF[2] set by cycle 16; OVF[1]=OVF[3]=0.
  - With SFQ_MERGE_DROP_CNT_EN defined, DCNT increments from the first drop onward.
- Load 4 pulses with AI=1111, then assert RI on the second ABO cycle -> next cycle ABO=0, BUSY=0, ACH=0, and no further ABO until new input.
- LAT=3 instance. AI=0100, BI=1111 at edge k -> ABO=1, ACH=2 only in the cycle after edge k+2; ABO=0 in all other cycles.
